// File: rtl/balance_seq.sv
// ---------------------------------------------------------------------------
// balance_seq
// Top-level sequencer for the balance-control PID datapath. Qualifies rider
// mount/dismount from the load cells, watches pitch magnitude for tilt faults
// and battery level for mount blocking. It drives the PID's power-up,
// rider-off and gated valid through a 4-state Moore FSM (IDLE/SOFT/RUN/FAULT).
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   vld_in     in   inertial sample strobe (pulses or held high)
//   ptch       in   [15:0] signed pitch
//   lft_ld     in   [11:0] unsigned left load cell
//   rght_ld    in   [11:0] unsigned right load cell
//   batt       in   [11:0] unsigned battery reading
//   ss_tmr     in   [7:0]  PID soft-start timer (0xFF = soft start done)
//   pid_vld    out  vld_in gated by SOFT/RUN (combinational, no latency)
//   pwr_up     out  motor drive enable, high in SOFT/RUN
//   rider_off  out  clears PID integrator, high in IDLE/FAULT
//   tilt_fault out  high while in FAULT
//   batt_low   out  registered battery-low flag with hysteresis
//   state      out  [1:0] IDLE=0, SOFT=1, RUN=2, FAULT=3
// ---------------------------------------------------------------------------
module balance_seq #(
    parameter logic [12:0] MIN_RIDER_WT  = 13'h0200,
    parameter logic [12:0] WT_HYST       = 13'h0040,
    parameter int unsigned DEB_SAMPLES   = 4,
    parameter logic [15:0] TILT_LIM      = 16'h1000,
    parameter int unsigned FAULT_SAMPLES = 3,
    parameter logic [11:0] BATT_LOW      = 12'h800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_in,
    input  logic [15:0] ptch,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic [11:0] batt,
    input  logic [7:0]  ss_tmr,
    output logic        pid_vld,
    output logic        pwr_up,
    output logic        rider_off,
    output logic        tilt_fault,
    output logic        batt_low,
    output logic [1:0]  state
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned SUM_W  = 13;
    localparam int unsigned PTCH_W = 16;

    // Dismount threshold and battery-clear threshold, widened so neither wraps.
    localparam logic [SUM_W-1:0] OFF_THR  = MIN_RIDER_WT - WT_HYST;
    localparam logic [12:0]      BATT_CLR = 13'(BATT_LOW) + 13'd16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOFT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;

    logic [CNT_W-1:0]   r_mount_cnt;
    logic [CNT_W-1:0]   r_dism_cnt;
    logic [CNT_W-1:0]   r_tilt_cnt;
    logic [CNT_W-1:0]   w_mount_cnt_nxt;
    logic [CNT_W-1:0]   w_dism_cnt_nxt;
    logic [CNT_W-1:0]   w_tilt_cnt_nxt;

    logic               r_batt_low;
    logic               w_batt_low_nxt;

    logic [SUM_W-1:0]   w_wt_sum;
    logic [PTCH_W-1:0]  w_ptch_abs;
    logic               w_on_cond;
    logic               w_off_cond;
    logic               w_tilt_cond;
    logic               w_mount_qual;

    logic               w_mount_hit;
    logic               w_dism_hit;
    logic               w_tilt_hit;
    logic               w_ss_done;
    logic               w_state_chg;

    // Saturating increment so a long qualifying run never wraps back to zero.
    function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] cnt);
        f_sat_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    endfunction

    // True when taking one more qualifying sample reaches the required run.
    function automatic logic f_run_done(input logic [CNT_W-1:0] cnt,
                                        input int unsigned      need);
        f_run_done = ((CNT_W+1)'(cnt) + (CNT_W+1)'(1)) >= (CNT_W+1)'(need);
    endfunction

    // Condition arithmetic
    assign w_wt_sum = SUM_W'(lft_ld) + SUM_W'(rght_ld);

    // Two's-complement magnitude; the most negative code saturates to max positive.
    always_comb begin
        w_ptch_abs = ptch;
        if (ptch[PTCH_W-1]) begin
            if (ptch == 16'h8000) begin
                w_ptch_abs = 16'h7FFF;
            end else begin
                w_ptch_abs = PTCH_W'(-ptch);
            end
        end
    end

    assign w_on_cond    = (w_wt_sum >= MIN_RIDER_WT);
    assign w_off_cond   = (w_wt_sum < OFF_THR);
    assign w_tilt_cond  = (w_ptch_abs > TILT_LIM);
    assign w_mount_qual = w_on_cond && !r_batt_low;

    // Exit events: the edge that takes the final qualifying sample of a run.
    assign w_mount_hit = vld_in && w_mount_qual && f_run_done(r_mount_cnt, DEB_SAMPLES);
    assign w_dism_hit  = vld_in && w_off_cond   && f_run_done(r_dism_cnt, DEB_SAMPLES);
    assign w_tilt_hit  = vld_in && w_tilt_cond  && f_run_done(r_tilt_cnt, FAULT_SAMPLES);
    assign w_ss_done   = (ss_tmr == 8'hFF);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Next-state logic; priority tilt fault > dismount > soft-start complete.
    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mount_hit) begin
                    w_nxt_state = ST_SOFT;
                end
            end
            ST_SOFT: begin
                if (w_tilt_hit) begin
                    w_nxt_state = ST_FAULT;
                end else if (w_dism_hit) begin
                    w_nxt_state = ST_IDLE;
                end else if (w_ss_done) begin
                    w_nxt_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tilt_hit) begin
                    w_nxt_state = ST_FAULT;
                end else if (w_dism_hit) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            ST_FAULT: begin
                if (w_dism_hit) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // Moore output decode straight off the state register.
    always_comb begin
        pwr_up     = 1'b0;
        rider_off  = 1'b1;
        tilt_fault = 1'b0;
        case (r_state)
            ST_SOFT, ST_RUN: begin
                pwr_up    = 1'b1;
                rider_off = 1'b0;
            end
            ST_FAULT: begin
                tilt_fault = 1'b1;
            end
            default: begin
                pwr_up     = 1'b0;
                rider_off  = 1'b1;
                tilt_fault = 1'b0;
            end
        endcase
    end

    assign state   = r_state;
    assign pid_vld = vld_in && ((r_state == ST_SOFT) || (r_state == ST_RUN));

    assign w_state_chg = (w_nxt_state != r_state);

    // Debounce counter next values: clear on state change, else advance on vld.
    always_comb begin
        w_mount_cnt_nxt = r_mount_cnt;
        w_dism_cnt_nxt  = r_dism_cnt;
        w_tilt_cnt_nxt  = r_tilt_cnt;
        if (w_state_chg) begin
            w_mount_cnt_nxt = '0;
            w_dism_cnt_nxt  = '0;
            w_tilt_cnt_nxt  = '0;
        end else if (vld_in) begin
            w_mount_cnt_nxt = w_mount_qual ? f_sat_inc(r_mount_cnt) : '0;
            w_dism_cnt_nxt  = w_off_cond   ? f_sat_inc(r_dism_cnt)  : '0;
            w_tilt_cnt_nxt  = w_tilt_cond  ? f_sat_inc(r_tilt_cnt)  : '0;
        end
    end

    // Debounce counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mount_cnt <= '0;
            r_dism_cnt  <= '0;
            r_tilt_cnt  <= '0;
        end else begin
            r_mount_cnt <= w_mount_cnt_nxt;
            r_dism_cnt  <= w_dism_cnt_nxt;
            r_tilt_cnt  <= w_tilt_cnt_nxt;
        end
    end

    // Battery-low hysteresis, sampled only on vld strobes.
    always_comb begin
        w_batt_low_nxt = r_batt_low;
        if (vld_in) begin
            if (batt < BATT_LOW) begin
                w_batt_low_nxt = 1'b1;
            end else if (13'(batt) >= BATT_CLR) begin
                w_batt_low_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batt_low <= 1'b0;
        end else begin
            r_batt_low <= w_batt_low_nxt;
        end
    end

    assign batt_low = r_batt_low;

endmodule

// File: tb/tb_balance_seq.sv
// ---------------------------------------------------------------------------
// tb_balance_seq
// Self-checking bench for balance_seq: directed scenarios followed by
// randomized segments, all checked every cycle against a behavioural model
// that tracks run lengths of qualifying samples since the last state entry.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_balance_seq;

    logic        clk;
    logic        rst_n;
    logic        vld_in;
    logic [15:0] ptch;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] batt;
    logic [7:0]  ss_tmr;
    logic        pid_vld;
    logic        pwr_up;
    logic        rider_off;
    logic        tilt_fault;
    logic        batt_low;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: state number and lengths of current qualifying sample runs.
    int m_state;
    int m_mount_run;
    int m_off_run;
    int m_tilt_run;
    bit m_bl;

    balance_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld_in     (vld_in),
        .ptch       (ptch),
        .lft_ld     (lft_ld),
        .rght_ld    (rght_ld),
        .batt       (batt),
        .ss_tmr     (ss_tmr),
        .pid_vld    (pid_vld),
        .pwr_up     (pwr_up),
        .rider_off  (rider_off),
        .tilt_fault (tilt_fault),
        .batt_low   (batt_low),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state     = 0;
        m_mount_run = 0;
        m_off_run   = 0;
        m_tilt_run  = 0;
        m_bl        = 1'b0;
    endtask

    // One clock edge of the rules, using the inputs present at that edge.
    task automatic model_edge();
        int  sum;
        int  p;
        int  mag;
        bit  on_c;
        bit  off_c;
        bit  tilt_c;
        int  nxt;
        sum    = int'(lft_ld) + int'(rght_ld);
        p      = int'($signed(ptch));
        mag    = (p < 0) ? -p : p;
        if (mag > 32767) mag = 32767;
        on_c   = (sum >= 512);
        off_c  = (sum < 512 - 64);
        tilt_c = (mag > 4096);
        if (vld_in) begin
            m_mount_run = (on_c && !m_bl) ? m_mount_run + 1 : 0;
            m_off_run   = off_c  ? m_off_run + 1  : 0;
            m_tilt_run  = tilt_c ? m_tilt_run + 1 : 0;
            if (int'(batt) < 2048)       m_bl = 1'b1;
            else if (int'(batt) >= 2064) m_bl = 1'b0;
        end
        nxt = m_state;
        case (m_state)
            0: if (m_mount_run >= 4) nxt = 1;
            1, 2: begin
                if (m_tilt_run >= 3)                nxt = 3;
                else if (m_off_run >= 4)            nxt = 0;
                else if (m_state == 1 && ss_tmr == 8'hFF) nxt = 2;
            end
            default: if (m_off_run >= 4) nxt = 0;
        endcase
        if (nxt != m_state) begin
            m_mount_run = 0;
            m_off_run   = 0;
            m_tilt_run  = 0;
        end
        m_state = nxt;
    endtask

    task automatic chk_outputs();
        chk("state",      16'(state),      16'(m_state));
        chk("pwr_up",     16'(pwr_up),     16'(m_state == 1 || m_state == 2));
        chk("rider_off",  16'(rider_off),  16'(m_state == 0 || m_state == 3));
        chk("tilt_fault", 16'(tilt_fault), 16'(m_state == 3));
        chk("batt_low",   16'(batt_low),   16'(m_bl));
    endtask

    // Called at posedge+1; checks the vld gate, takes one edge, checks outputs.
    task automatic step();
        #1;
        chk("pid_vld", 16'(pid_vld), 16'(vld_in && (m_state == 1 || m_state == 2)));
        @(posedge clk);
        model_edge();
        #1;
        chk_outputs();
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_ld(input logic [11:0] l, input logic [11:0] r);
        lft_ld  = l;
        rght_ld = r;
    endtask

    // Asynchronous reset applied away from the clock edge.
    task automatic reset_dut();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outputs();
        chk("rst_pid_vld", 16'(pid_vld), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // From reset: mount with a healthy battery, then finish soft start.
    task automatic go_run();
        reset_dut();
        vld_in = 1'b1; ptch = 16'h0; batt = 12'hA00; ss_tmr = 8'h00;
        set_ld(12'h120, 12'h120);
        step_n(4);
        ss_tmr = 8'hFF;
        step();
        ss_tmr = 8'h00;
        chk("go_run", 16'(state), 16'd2);
    endtask

    initial begin
        rst_n = 1'b0; vld_in = 1'b0; ptch = '0; lft_ld = '0; rght_ld = '0;
        batt = 12'hA00; ss_tmr = '0;
        model_reset();
        @(posedge clk);
        #1;
        reset_dut();

        // Idle with no rider
        vld_in = 1'b1; set_ld(12'h000, 12'h000);
        step_n(6);
        chk("idle_state", 16'(state), 16'd0);

        // Mount debounce: SOFT on 4th sample
        set_ld(12'h120, 12'h120);
        step_n(3);
        chk("mount_3", 16'(state), 16'd0);
        step();
        chk("mount_4", 16'(state), 16'd1);

        // Soft start: FE holds, FF advances
        ss_tmr = 8'hFE; step_n(5);
        chk("ss_fe", 16'(state), 16'd1);
        ss_tmr = 8'hFF; vld_in = 1'b0; step();
        chk("ss_ff", 16'(state), 16'd2);
        ss_tmr = 8'h00; vld_in = 1'b1; step_n(2);

        // Async reset from RUN lands before the next edge
        rst_n = 1'b0;
        #2;
        chk("async_rst", 16'(state), 16'd0);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // Mount restart on a light sample
        reset_dut();
        vld_in = 1'b1; set_ld(12'h120, 12'h120);
        step_n(2);
        set_ld(12'h080, 12'h080); step();
        set_ld(12'h120, 12'h120); step_n(3);
        chk("restart_3", 16'(state), 16'd0);
        step();
        chk("restart_4", 16'(state), 16'd1);

        // 50% vld: 8 clocks for 4 samples
        reset_dut();
        for (int i = 0; i < 8; i++) begin
            vld_in = 1'(i % 2);
            step();
            if (i == 6) chk("half_7", 16'(state), 16'd0);
        end
        chk("half_8", 16'(state), 16'd1);

        // Tilt positive, then FAULT exits only on dismount
        go_run();
        vld_in = 1'b1; ptch = 16'h1001; step_n(3);
        chk("tilt_pos", 16'(state), 16'd3);
        ptch = 16'h0000; step_n(10);
        chk("fault_hold", 16'(state), 16'd3);
        set_ld(12'h080, 12'h080); step_n(4);
        chk("fault_exit", 16'(state), 16'd0);

        // Tilt negative
        go_run();
        ptch = 16'hEFFF; step_n(3);
        chk("tilt_neg", 16'(state), 16'd3);

        // Exactly at limit, and a broken run: no fault
        go_run();
        ptch = 16'h1000; step_n(40);
        chk("tilt_eq", 16'(state), 16'd2);
        ptch = 16'h1001; step_n(2);
        ptch = 16'h0000; step();
        ptch = 16'h1001; step();
        ptch = 16'h0000;
        chk("tilt_broken", 16'(state), 16'd2);

        // Dismount hysteresis band holds, below band exits
        set_ld(12'h0E8, 12'h0E8); step_n(100);
        chk("hyst_band", 16'(state), 16'd2);
        set_ld(12'h0DF, 12'h0E0); step_n(3);
        chk("dism_3", 16'(state), 16'd2);
        step();
        chk("dism_4", 16'(state), 16'd0);

        // Tilt and dismount completing together: fault wins
        go_run();
        set_ld(12'h0DF, 12'h0E0); step();
        ptch = 16'h8000; step_n(3);
        chk("prio", 16'(state), 16'd3);
        ptch = 16'h0000;

        // Battery hysteresis blocks mounting
        reset_dut();
        vld_in = 1'b1; batt = 12'h7FF; set_ld(12'h120, 12'h120);
        step();
        chk("bl_set", 16'(batt_low), 16'd1);
        step_n(10);
        chk("bl_block", 16'(state), 16'd0);
        batt = 12'h80F; step_n(3);
        chk("bl_hold", 16'(batt_low), 16'd1);
        batt = 12'h810; step();
        chk("bl_clr", 16'(batt_low), 16'd0);
        step_n(3);
        chk("bl_mnt3", 16'(state), 16'd0);
        step();
        chk("bl_mnt4", 16'(state), 16'd1);

        // Randomized segments against the model
        for (int s = 0; s < 400; s++) begin
            int hold;
            int k;
            logic [11:0] ld_tab [6];
            logic [15:0] p_tab [8];
            logic [11:0] b_tab [6];
            ld_tab = '{12'h000, 12'h0DF, 12'h0E0, 12'h0E8, 12'h100, 12'h120};
            p_tab  = '{16'h0000, 16'h1000, 16'h1001, 16'hEFFF, 16'hF000,
                       16'h8000, 16'h7FFF, 16'h0123};
            b_tab  = '{12'h7FF, 12'h800, 12'h80F, 12'h810, 12'hA00, 12'hA00};
            k = int'($urandom_range(0, 5));
            lft_ld  = ld_tab[k];
            rght_ld = (($urandom_range(0, 3)) == 0) ? 12'($urandom) : ld_tab[k];
            ptch    = ($urandom_range(0, 2) == 0) ? p_tab[$urandom_range(0, 7)] : 16'h0000;
            batt    = b_tab[$urandom_range(0, 5)];
            hold    = int'($urandom_range(1, 10));
            for (int c = 0; c < hold; c++) begin
                vld_in = ($urandom_range(0, 3) != 0);
                ss_tmr = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                step();
            end
            if (s == 200) begin
                reset_dut();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, limit 2000000 ns");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
